// File: rtl/char_writer_pkg.sv
// Shared definitions for the terminal character writer:
// screen geometry, ASCII codes and FSM states.
package char_writer_pkg;

  localparam int DEF_COLS      = 80;
  localparam int DEF_ROWS      = 25;
  localparam int DEF_BUF_SIZE  = 2000;
  localparam int DEF_ADDR_BITS = 11;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_ALL  = 2'd1,
    CLEAR_LINE = 2'd2
  } state_e;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/char_writer.sv
// Terminal-style byte stream front end for the character buffer.
// Scrolls by rotating top_line; row_base tracks the physical row start.
module char_writer
  import char_writer_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int BUF_SIZE  = DEF_BUF_SIZE,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [ADDR_BITS-1:0] buf_waddr,
  output logic [7:0]           buf_din,
  output logic                 buf_wen,
  output logic [4:0]           top_line,
  output logic [6:0]           cursor_col,
  output logic [4:0]           cursor_row,
  output logic                 busy
);

  localparam logic [ADDR_BITS-1:0] LAST_CELL = ADDR_BITS'(BUF_SIZE - 1);
  localparam logic [ADDR_BITS-1:0] LAST_BASE = ADDR_BITS'(BUF_SIZE - COLS);
  localparam logic [ADDR_BITS-1:0] COLS_A    = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] LAST_CLR  = ADDR_BITS'(COLS - 1);
  localparam logic [6:0]           LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]           LAST_ROW  = 5'(ROWS - 1);

  state_e                 state, state_n;
  logic [ADDR_BITS-1:0]   cnt, cnt_n;
  logic [ADDR_BITS-1:0]   row_base, base_n;
  logic [ADDR_BITS-1:0]   base_adv;
  logic [ADDR_BITS-1:0]   waddr_n;
  logic [7:0]             din_n;
  logic                   wen_n;
  logic                   rdy_n;
  logic [4:0]             top_n;
  logic [6:0]             col_n;
  logic [4:0]             row_n;
  logic                   accept;
  logic                   newline;

  assign accept   = rx_valid && rx_ready;
  assign base_adv = (row_base == LAST_BASE) ? '0 : row_base + COLS_A;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    base_n  = row_base;
    waddr_n = buf_waddr;
    din_n   = CH_SPACE;
    wen_n   = 1'b0;
    top_n   = top_line;
    col_n   = cursor_col;
    row_n   = cursor_row;
    newline = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_print(rx_data): begin
              wen_n   = 1'b1;
              waddr_n = row_base + ADDR_BITS'(cursor_col);
              din_n   = rx_data;
              if (cursor_col == LAST_COL) begin
                col_n   = '0;
                newline = 1'b1;
              end else begin
                col_n = cursor_col + 7'd1;
              end
            end
            (rx_data == CH_LF): begin
              col_n   = '0;
              newline = 1'b1;
            end
            (rx_data == CH_CR): col_n = '0;
            (rx_data == CH_BS): begin
              if (cursor_col != '0)
                col_n = cursor_col - 7'd1;
            end
            (rx_data == CH_FF): begin
              state_n = CLEAR_ALL;
              cnt_n   = '0;
            end
            default: ;
          endcase
        end
        // Bottom row scrolls: the cursor row now maps to the next physical row.
        if (newline) begin
          base_n = base_adv;
          if (cursor_row != LAST_ROW) begin
            row_n = cursor_row + 5'd1;
          end else begin
            top_n   = (top_line == LAST_ROW) ? '0 : top_line + 5'd1;
            state_n = CLEAR_LINE;
            cnt_n   = '0;
          end
        end
      end
      CLEAR_ALL: begin
        wen_n   = 1'b1;
        waddr_n = cnt;
        cnt_n   = cnt + 1'b1;
        if (cnt == LAST_CELL) begin
          state_n = IDLE;
          cnt_n   = '0;
          top_n   = '0;
          col_n   = '0;
          row_n   = '0;
          base_n  = '0;
        end
      end
      CLEAR_LINE: begin
        wen_n   = 1'b1;
        waddr_n = row_base + cnt;
        cnt_n   = cnt + 1'b1;
        if (cnt == LAST_CLR) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = CLEAR_ALL;
        cnt_n   = '0;
      end
    endcase

    rdy_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR_ALL;
      cnt        <= '0;
      row_base   <= '0;
      buf_wen    <= 1'b0;
      buf_waddr  <= '0;
      buf_din    <= CH_SPACE;
      rx_ready   <= 1'b0;
      busy       <= 1'b1;
      top_line   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      row_base   <= base_n;
      buf_wen    <= wen_n;
      buf_waddr  <= waddr_n;
      buf_din    <= din_n;
      rx_ready   <= rdy_n;
      busy       <= !rdy_n;
      top_line   <= top_n;
      cursor_col <= col_n;
      cursor_row <= row_n;
    end
  end

endmodule

// File: tb/tb_char_writer.sv
// Directed bench for char_writer: vector table for IDLE bytes,
// hand sequences for clears, scrolling, reset abort and held bytes.
module tb_char_writer;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [10:0] buf_waddr;
  logic [7:0]  buf_din;
  logic        buf_wen;
  logic [4:0]  top_line;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  char_writer dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .buf_waddr  (buf_waddr),
    .buf_din    (buf_din),
    .buf_wen    (buf_wen),
    .top_line   (top_line),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         rep;
    bit         wen;
    int         addr;
    logic [7:0] din;
    int         col;
    int         row;
    int         top;
    bit         rdy;
    int         clr_base;
    int         clr_n;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for rx_ready, then presents one byte for one edge.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!rx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("ready_timeout", 0, 1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic watch_writes(input string name, input int base, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (!buf_wen || int'(buf_waddr) != base + i || buf_din != 8'h20) bad++;
      if (i < n - 1 && rx_ready) bad++;
      if (i == n - 1 && !rx_ready) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin
    int acc, kw, kaddr;
    logic r, v;

    tbl[0]  = '{8'h08, 1,  1'b0, 0,   8'h00, 1,  0,  0, 1'b1, 0, 0};
    tbl[1]  = '{8'h0D, 1,  1'b0, 0,   8'h00, 0,  0,  0, 1'b1, 0, 0};
    tbl[2]  = '{8'h08, 1,  1'b0, 0,   8'h00, 0,  0,  0, 1'b1, 0, 0};
    tbl[3]  = '{8'h01, 1,  1'b0, 0,   8'h00, 0,  0,  0, 1'b1, 0, 0};
    tbl[4]  = '{8'h63, 1,  1'b1, 0,   8'h63, 1,  0,  0, 1'b1, 0, 0};
    tbl[5]  = '{8'h0A, 1,  1'b0, 0,   8'h00, 0,  1,  0, 1'b1, 0, 0};
    tbl[6]  = '{8'h64, 1,  1'b1, 80,  8'h64, 1,  1,  0, 1'b1, 0, 0};
    tbl[7]  = '{8'h0A, 2,  1'b0, 0,   8'h00, 0,  3,  0, 1'b1, 0, 0};
    tbl[8]  = '{8'h20, 79, 1'b1, 318, 8'h20, 79, 3,  0, 1'b1, 0, 0};
    tbl[9]  = '{8'h78, 1,  1'b1, 319, 8'h78, 0,  4,  0, 1'b1, 0, 0};
    tbl[10] = '{8'h0A, 20, 1'b0, 0,   8'h00, 0,  24, 0, 1'b1, 0, 0};
    tbl[11] = '{8'h0A, 1,  1'b0, 0,   8'h00, 0,  24, 1, 1'b0, 0, 80};
    tbl[12] = '{8'h5A, 1,  1'b1, 0,   8'h5A, 1,  24, 1, 1'b1, 0, 0};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", buf_wen, 0);
    chk("rst_waddr", buf_waddr, 0);
    chk("rst_din", buf_din, 8'h20);
    chk("rst_ready", rx_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_top", top_line, 0);
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);

    @(negedge clk);
    reset = 1'b0;
    watch_writes("clear_all_boot", 0, 2000);
    chk("boot_busy", busy, 0);
    chk("boot_col", cursor_col, 0);
    chk("boot_row", cursor_row, 0);

    // Back-to-back printable bytes
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(posedge clk);
    #1;
    chk("ab_wen0", buf_wen, 1);
    chk("ab_addr0", buf_waddr, 0);
    chk("ab_din0", buf_din, 8'h41);
    rx_data = 8'h42;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("ab_wen1", buf_wen, 1);
    chk("ab_addr1", buf_waddr, 1);
    chk("ab_din1", buf_din, 8'h42);
    chk("ab_col", cursor_col, 2);
    @(posedge clk);
    #1;
    chk("ab_idle_wen", buf_wen, 0);

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < tbl[i].rep; k++) send(tbl[i].d);
      chk($sformatf("v%0d_wen", i), buf_wen, tbl[i].wen);
      if (tbl[i].wen) begin
        chk($sformatf("v%0d_addr", i), buf_waddr, tbl[i].addr);
        chk($sformatf("v%0d_din", i), buf_din, tbl[i].din);
      end
      chk($sformatf("v%0d_col", i), cursor_col, tbl[i].col);
      chk($sformatf("v%0d_row", i), cursor_row, tbl[i].row);
      chk($sformatf("v%0d_top", i), top_line, tbl[i].top);
      chk($sformatf("v%0d_rdy", i), rx_ready, tbl[i].rdy);
      if (tbl[i].clr_n > 0)
        watch_writes($sformatf("v%0d_clr", i), tbl[i].clr_base, tbl[i].clr_n);
    end

    // Scroll up to top_line 24
    for (int k = 2; k <= 24; k++) begin
      send(8'h0A);
      if (top_line != 5'(k)) chk("scroll_top", top_line, k);
      watch_writes($sformatf("scroll%0d_clr", k), (k - 1) * 80, 80);
    end
    chk("top24", top_line, 24);
    send(8'h0D);
    repeat (5) send(8'h20);
    send(8'h51);
    chk("q_wen", buf_wen, 1);
    chk("q_addr", buf_waddr, 1845);
    chk("q_din", buf_din, 8'h51);
    chk("q_col", cursor_col, 6);

    // top_line wrap 24 -> 0, then 0 -> 1
    send(8'h0A);
    chk("wrap_top", top_line, 0);
    watch_writes("wrap_clr", 1920, 80);
    send(8'h0A);
    chk("wrap_top1", top_line, 1);
    watch_writes("wrap1_clr", 0, 80);
    send(8'h52);
    chk("r_addr", buf_waddr, 0);
    chk("r_col", cursor_col, 1);

    // Form feed mid-stream
    send(8'h0C);
    chk("ff_rdy", rx_ready, 0);
    chk("ff_busy", busy, 1);
    watch_writes("ff_clr", 0, 2000);
    chk("ff_col", cursor_col, 0);
    chk("ff_row", cursor_row, 0);
    chk("ff_top", top_line, 0);

    // Reset pulse mid-clear
    send(8'h0C);
    repeat (300) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_wen", buf_wen, 0);
    chk("midrst_addr", buf_waddr, 0);
    chk("midrst_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    watch_writes("midrst_clr", 0, 2000);

    // Byte held during a clear is taken exactly once afterwards
    send(8'h0C);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h4B;
    acc   = 0;
    kw    = 0;
    kaddr = -1;
    for (int c = 0; c < 2100; c++) begin
      r = rx_ready;
      v = rx_valid;
      @(posedge clk);
      #1;
      if (r && v) begin
        acc++;
        rx_valid = 1'b0;
      end
      if (buf_wen && buf_din == 8'h4B) begin
        kw++;
        kaddr = int'(buf_waddr);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("held_accepts", acc, 1);
    chk("held_writes", kw, 1);
    chk("held_addr", kaddr, 0);
    chk("held_col", cursor_col, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
